// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC producer with fetch/execute FSM and return stack.
// Ports: clock, reset (async low), current_address, instr_valid, instr_op,
//   instr_target, zero_flag, mem_busy -> next_address, fetch_req, halted,
//   stack_err, plus retired_count when PC_SEQ_PERF_EN is defined.
module pc_sequencer #(
  parameter int unsigned STACK_DEPTH  = 4,
  parameter logic [7:0]  RESET_VECTOR = 8'h00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  current_address,
  input  logic        instr_valid,
  input  logic [2:0]  instr_op,
  input  logic [7:0]  instr_target,
  input  logic        zero_flag,
  input  logic        mem_busy,
  output logic [7:0]  next_address,
  output logic        fetch_req,
  output logic        halted,
  output logic        stack_err
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [15:0] retired_count
`endif
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_HALT
  } state_t;

  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_BZ   = 3'b010;
  localparam logic [2:0] OP_BNZ  = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b110;

  localparam logic [3:0] DEPTH = 4'(STACK_DEPTH);

  state_t     state;
  state_t     state_d;
  logic [2:0] op_q;
  logic [7:0] tgt_q;
  logic [3:0] sp;
  logic [7:0] stk [8];
  logic [7:0] inc;
  logic [7:0] addr;
  logic [2:0] top;
  logic       full;
  logic       empty;
  logic       done;
  logic       push;
  logic       pop;
  logic       err_d;

  assign inc   = current_address + 8'd1;
  assign full  = (sp == DEPTH);
  assign empty = (sp == 4'd0);
  assign top   = 3'(sp - 4'd1);
  assign done  = (state == S_EXEC) && !mem_busy;

  // Target selection for the latched instruction.
  always_comb begin
    addr  = inc;
    push  = 1'b0;
    pop   = 1'b0;
    err_d = 1'b0;
    case (op_q)
      OP_JMP:  addr = tgt_q;
      OP_BZ:   if (zero_flag) addr = tgt_q;
      OP_BNZ:  if (!zero_flag) addr = tgt_q;
      OP_CALL: begin
        if (full) begin
          err_d = 1'b1;
        end else begin
          push = 1'b1;
          addr = tgt_q;
        end
      end
      OP_RET: begin
        if (empty) begin
          err_d = 1'b1;
        end else begin
          pop  = 1'b1;
          addr = stk[top];
        end
      end
      OP_HALT: addr = current_address;
      default: addr = inc;
    endcase
  end

  always_comb begin
    state_d      = state;
    next_address = current_address;
    fetch_req    = 1'b0;
    case (state)
      S_FETCH: begin
        fetch_req = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (instr_valid) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (!mem_busy) begin
          next_address = addr;
          state_d = (op_q == OP_HALT) ? S_HALT : S_FETCH;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    // Reset overrides the outputs combinationally.
    if (!reset) begin
      next_address = RESET_VECTOR;
      fetch_req    = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_FETCH;
      op_q      <= 3'd0;
      tgt_q     <= 8'd0;
      sp        <= 4'd0;
      stack_err <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state <= state_d;
      if (state == S_WAIT && instr_valid) begin
        op_q  <= instr_op;
        tgt_q <= instr_target;
      end
      if (done) begin
        if (push) sp <= sp + 4'd1;
        if (pop) sp <= sp - 4'd1;
        if (err_d) stack_err <= 1'b1;
        if (op_q == OP_HALT) halted <= 1'b1;
      end
    end
  end

  // Stack contents need no reset; the pointer defines validity.
  always_ff @(posedge clock) begin
    if (done && push) stk[sp[2:0]] <= inc;
  end

`ifdef PC_SEQ_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      retired_count <= 16'd0;
    end else if (done && retired_count != 16'hFFFF) begin
      retired_count <= retired_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: self-checking bench for pc_sequencer.
// Emulates the PC register and compares against a queue-based flow model.
module tb_pc_sequencer;

  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] pc = 8'h00;
  logic       instr_valid = 1'b0;
  logic [2:0] instr_op = 3'd0;
  logic [7:0] instr_target = 8'h00;
  logic       zero_flag = 1'b0;
  logic       mem_busy = 1'b0;
  logic [7:0] next_address;
  logic       fetch_req;
  logic       halted;
  logic       stack_err;
`ifdef PC_SEQ_PERF_EN
  logic [15:0] retired_count;
`endif

  int checks = 0;
  int failures = 0;

  logic [7:0] mstack[$];
  logic       merr = 1'b0;

  pc_sequencer #(
    .STACK_DEPTH(DEPTH),
    .RESET_VECTOR(8'h00)
  ) dut (
    .clock(clock),
    .reset(reset),
    .current_address(pc),
    .instr_valid(instr_valid),
    .instr_op(instr_op),
    .instr_target(instr_target),
    .zero_flag(zero_flag),
    .mem_busy(mem_busy),
    .next_address(next_address),
    .fetch_req(fetch_req),
    .halted(halted),
    .stack_err(stack_err)
`ifdef PC_SEQ_PERF_EN
    ,
    .retired_count(retired_count)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) pc <= next_address;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic model_step(
    input  logic [2:0] op,
    input  logic [7:0] a,
    input  logic [7:0] t,
    input  logic       zf,
    output logic [7:0] exp
  );
    logic [7:0] a1;
    a1 = a + 8'd1;
    case (op)
      3'd1: exp = t;
      3'd2: exp = zf ? t : a1;
      3'd3: exp = zf ? a1 : t;
      3'd4: begin
        if (mstack.size() < DEPTH) begin
          mstack.push_back(a1);
          exp = t;
        end else begin
          merr = 1'b1;
          exp = a1;
        end
      end
      3'd5: begin
        if (mstack.size() > 0) begin
          exp = mstack.pop_back();
        end else begin
          merr = 1'b1;
          exp = a1;
        end
      end
      3'd6: exp = a;
      default: exp = a1;
    endcase
  endtask

  // Runs one instruction; entry and exit are just after a falling
  // edge with the DUT in FETCH.
  task automatic do_instr(
    input  logic [2:0] op,
    input  logic [7:0] t,
    input  logic       zf,
    input  int         nwait,
    input  int         nbusy,
    output logic       o_freq,
    output logic       o_quiet,
    output logic [7:0] o_pc,
    output logic [7:0] o_next
  );
    o_freq  = fetch_req;
    o_quiet = 1'b1;
    @(posedge clock);
    @(negedge clock);
    #1;
    for (int i = 0; i < nwait; i++) begin
      if (fetch_req !== 1'b0 || next_address !== pc) o_quiet = 1'b0;
      instr_op = 3'($urandom);
      instr_target = 8'($urandom);
      @(posedge clock);
      @(negedge clock);
      #1;
    end
    if (fetch_req !== 1'b0 || next_address !== pc) o_quiet = 1'b0;
    instr_valid = 1'b1;
    instr_op = op;
    instr_target = t;
    @(posedge clock);
    #1;
    instr_valid = 1'b0;
    instr_op = 3'($urandom);
    instr_target = 8'($urandom);
    for (int i = 0; i < nbusy; i++) begin
      mem_busy = 1'b1;
      zero_flag = 1'($urandom);
      @(negedge clock);
      #1;
      if (fetch_req !== 1'b0 || next_address !== pc) o_quiet = 1'b0;
      @(posedge clock);
      #1;
    end
    mem_busy = 1'b0;
    zero_flag = zf;
    @(negedge clock);
    #1;
    o_pc = pc;
    o_next = next_address;
    if (fetch_req !== 1'b0) o_quiet = 1'b0;
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    checks++;
    if (next_address !== 8'h00) begin
      failures++;
      $display("FAIL reset_next got=%h exp=00", next_address);
    end
    checks++;
    if (fetch_req !== 1'b0 || halted !== 1'b0 || stack_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b%b%b exp=000",
               fetch_req, halted, stack_err);
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (fetch_req !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_fetch got=%b exp=1", fetch_req);
    end
  endtask

  task automatic test_seq();
    logic f, q;
    logic [7:0] a, n, e;
    for (int i = 0; i < 3; i++) begin
      do_instr(3'd0, 8'h00, 1'b0, 0, 0, f, q, a, n);
      model_step(3'd0, a, 8'h00, 1'b0, e);
      checks++;
      if (n !== e || e !== 8'(i + 1) || f !== 1'b1 || q !== 1'b1) begin
        failures++;
        $display("FAIL seq%0d next=%h exp=%h freq=%b quiet=%b",
                 i, n, 8'(i + 1), f, q);
      end
    end
  endtask

  task automatic test_wrap();
    logic f, q;
    logic [7:0] a, n, e;
    do_instr(3'd1, 8'hFF, 1'b0, 0, 0, f, q, a, n);
    model_step(3'd1, a, 8'hFF, 1'b0, e);
    do_instr(3'd7, 8'h33, 1'b0, 1, 0, f, q, a, n);
    model_step(3'd7, a, 8'h33, 1'b0, e);
    checks++;
    if (a !== 8'hFF || n !== 8'h00) begin
      failures++;
      $display("FAIL wrap pc=%h next=%h exp=00", a, n);
    end
  endtask

  task automatic test_branch();
    logic f, q;
    logic [7:0] a, n, e, x;
    logic [2:0] ops [4];
    logic       zfs [4];
    logic [7:0] exps [4];
    ops = '{3'd2, 3'd2, 3'd3, 3'd3};
    zfs = '{1'b1, 1'b0, 1'b0, 1'b1};
    exps = '{8'h40, 8'h11, 8'h40, 8'h11};
    for (int i = 0; i < 4; i++) begin
      do_instr(3'd1, 8'h10, 1'b0, 0, 0, f, q, a, n);
      model_step(3'd1, a, 8'h10, 1'b0, x);
      do_instr(ops[i], 8'h40, zfs[i], 0, 0, f, q, a, n);
      model_step(ops[i], a, 8'h40, zfs[i], e);
      checks++;
      if (n !== exps[i] || n !== e) begin
        failures++;
        $display("FAIL branch%0d next=%h exp=%h", i, n, exps[i]);
      end
    end
  endtask

  task automatic test_call_ret();
    logic f, q;
    logic [7:0] a, n, e;
    do_instr(3'd1, 8'h20, 1'b0, 0, 0, f, q, a, n);
    model_step(3'd1, a, 8'h20, 1'b0, e);
    do_instr(3'd4, 8'h80, 1'b0, 0, 0, f, q, a, n);
    model_step(3'd4, a, 8'h80, 1'b0, e);
    checks++;
    if (n !== 8'h80) begin
      failures++;
      $display("FAIL call next=%h exp=80", n);
    end
    do_instr(3'd1, 8'h85, 1'b0, 0, 0, f, q, a, n);
    model_step(3'd1, a, 8'h85, 1'b0, e);
    do_instr(3'd5, 8'h00, 1'b0, 0, 0, f, q, a, n);
    model_step(3'd5, a, 8'h00, 1'b0, e);
    checks++;
    if (n !== 8'h21 || stack_err !== 1'b0) begin
      failures++;
      $display("FAIL ret next=%h err=%b exp=21/0", n, stack_err);
    end
  endtask

  task automatic test_stack_bounds();
    logic f, q;
    logic [7:0] a, n, e;
    for (int i = 0; i < 5; i++) begin
      do_instr(3'd4, 8'(8'h30 + 8'(i * 16)), 1'b0, 0, 0, f, q, a, n);
      model_step(3'd4, a, 8'(8'h30 + 8'(i * 16)), 1'b0, e);
      checks++;
      if (n !== e || stack_err !== merr) begin
        failures++;
        $display("FAIL call_nest%0d next=%h exp=%h err=%b exp=%b",
                 i, n, e, stack_err, merr);
      end
    end
    checks++;
    if (stack_err !== 1'b1 || n !== 8'(a + 8'd1)) begin
      failures++;
      $display("FAIL overflow next=%h err=%b exp=%h/1",
               n, stack_err, 8'(a + 8'd1));
    end
    for (int i = 0; i < 5; i++) begin
      do_instr(3'd5, 8'h00, 1'b0, 0, 0, f, q, a, n);
      model_step(3'd5, a, 8'h00, 1'b0, e);
      checks++;
      if (n !== e || stack_err !== 1'b1) begin
        failures++;
        $display("FAIL unwind%0d next=%h exp=%h err=%b exp=1",
                 i, n, e, stack_err);
      end
    end
  endtask

  task automatic test_mem_busy();
    logic f, q;
    logic [7:0] a, n, e;
    do_instr(3'd1, 8'h50, 1'b0, 2, 4, f, q, a, n);
    model_step(3'd1, a, 8'h50, 1'b0, e);
    checks++;
    if (n !== 8'h50 || q !== 1'b1 || f !== 1'b1) begin
      failures++;
      $display("FAIL mem_busy next=%h quiet=%b freq=%b exp=50/1/1",
               n, q, f);
    end
  endtask

  task automatic test_random();
    logic f, q;
    logic [7:0] a, n, e, t;
    logic [2:0] op;
    logic       zf;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 6));
      if (op == 3'd6) op = 3'd7;
      t = 8'($urandom);
      zf = 1'($urandom);
      do_instr(op, t, zf, $urandom_range(0, 3), $urandom_range(0, 3),
               f, q, a, n);
      model_step(op, a, t, zf, e);
      checks++;
      if (n !== e || stack_err !== merr || f !== 1'b1 || q !== 1'b1) begin
        failures++;
        $display("FAIL rand%0d op=%0d next=%h exp=%h err=%b exp=%b f=%b q=%b",
                 i, op, n, e, stack_err, merr, f, q);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic f, q;
    logic [7:0] a, n, e;
    do_instr(3'd4, 8'h90, 1'b0, 0, 0, f, q, a, n);
    model_step(3'd4, a, 8'h90, 1'b0, e);
    do_instr(3'd4, 8'h91, 1'b0, 0, 0, f, q, a, n);
    model_step(3'd4, a, 8'h91, 1'b0, e);
    @(posedge clock);
    @(negedge clock);
    #1;
    instr_valid = 1'b1;
    instr_op = 3'd5;
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (next_address !== 8'h00 || fetch_req !== 1'b0 ||
        halted !== 1'b0 || stack_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid next=%h freq=%b halt=%b err=%b exp=00/0/0/0",
               next_address, fetch_req, halted, stack_err);
    end
    mstack.delete();
    merr = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    instr_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (fetch_req !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_fetch got=%b exp=1", fetch_req);
    end
    do_instr(3'd5, 8'h00, 1'b0, 0, 0, f, q, a, n);
    model_step(3'd5, a, 8'h00, 1'b0, e);
    checks++;
    if (n !== 8'h01 || stack_err !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_ret next=%h err=%b exp=01/1", n, stack_err);
    end
  endtask

  task automatic test_halt();
    logic f, q, ok;
    logic [7:0] a, n, e;
    do_instr(3'd1, 8'h60, 1'b0, 0, 0, f, q, a, n);
    model_step(3'd1, a, 8'h60, 1'b0, e);
    do_instr(3'd6, 8'h77, 1'b0, 1, 1, f, q, a, n);
    model_step(3'd6, a, 8'h77, 1'b0, e);
    checks++;
    if (n !== 8'h60) begin
      failures++;
      $display("FAIL halt_next got=%h exp=60", n);
    end
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      instr_valid = 1'($urandom);
      if (halted !== 1'b1 || fetch_req !== 1'b0 || next_address !== pc)
        ok = 1'b0;
      @(negedge clock);
      #1;
    end
    instr_valid = 1'b0;
    checks++;
    if (ok !== 1'b1 || pc !== 8'h60) begin
      failures++;
      $display("FAIL halt_hold ok=%b pc=%h exp=1/60", ok, pc);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (next_address !== 8'h00 || halted !== 1'b0 || stack_err !== 1'b0) begin
      failures++;
      $display("FAIL halt_reset next=%h halt=%b err=%b exp=00/0/0",
               next_address, halted, stack_err);
    end
    mstack.delete();
    merr = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (fetch_req !== 1'b1) begin
      failures++;
      $display("FAIL halt_restart_fetch got=%b exp=1", fetch_req);
    end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_wrap();
    test_branch();
    test_call_ret();
    test_stack_bounds();
    test_mem_busy();
    test_random();
    test_reset_mid();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Control-path producer for the 8-bit program counter. Each cycle it drives `next_address`, which the PC register loads unconditionally on every rising clock edge. A fetch/execute FSM sequences single-memory instruction fetch. The block resolves sequential, jump, conditional-branch, call and return flow. A small return-address stack is internal to the block.

Parameters:
- STACK_DEPTH, 4, number of return-address entries (1..8).
- RESET_VECTOR, 8'h00, address driven on `next_address` while in reset and after HALT release by reset.

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- current_address  in  8  PC register output
- instr_valid  in  1  memory has returned the fetched instruction this cycle
- instr_op  in  3  flow class: 000 SEQ, 001 JMP, 010 BZ, 011 BNZ, 100 CALL, 101 RET, 110 HALT, 111 treated as SEQ
- instr_target  in  8  absolute branch/jump/call target
- zero_flag  in  1  ALU zero flag
- mem_busy  in  1  execute-phase data memory access in progress
- next_address  out  8  address the PC loads on the next edge
- fetch_req  out  1  one-cycle instruction fetch request at `current_address`
- halted  out  1  HALT executed
- stack_err  out  1  sticky: overflow or underflow occurred

Behaviour:
- States: FETCH, WAIT, EXEC, HALT. Reset state is FETCH.
- Reset asserted (low): FSM goes to FETCH, stack pointer 0, `stack_err`=0, `halted`=0, `fetch_req`=0, `next_address`=RESET_VECTOR (combinational override).
- `next_address` is combinational. In FETCH, WAIT and HALT it equals `current_address`, so the PC holds.
- FETCH: `fetch_req`=1 for exactly this cycle, then go to WAIT. `instr_valid` is ignored in FETCH.
- WAIT: stay until `instr_valid`=1. On that cycle, latch `instr_op`/`instr_target` and go to EXEC.
- EXEC with `mem_busy`=1: stay in EXEC, `next_address`=`current_address`.
- EXEC with `mem_busy`=0: drive the computed address for one cycle, then go to FETCH (or HALT). `zero_flag` is sampled in this cycle.
- Address computation (all 8-bit, modulo 256; A = `current_address`, A+1 of 8'hFF is 8'h00):
  - SEQ/111: A+1.
  - JMP: target.
  - BZ: target if `zero_flag`, else A+1.
  - BNZ: target if not `zero_flag`, else A+1.
  - CALL: push A+1, then target.
  - RET: pop, next = popped value.
  - HALT: A; FSM enters HALT, `halted`=1 registered.
- Stack boundaries:
  - CALL with stack full: no push, `stack_err`=1, next = A+1.
  - RET with stack empty: no pop, `stack_err`=1, next = A+1.
  - `stack_err` clears only on reset.
- HALT is terminal: the FSM leaves HALT only via reset, and `fetch_req` stays 0 while halted.
- Minimum instruction period is 3 cycles (FETCH, WAIT with immediate `instr_valid`, EXEC). The PC changes at the EXEC edge.
- Reset mid-instruction: latched instruction discarded, no stack update completes, FSM restarts at FETCH.

Optional Feature:
- Macro: PC_SEQ_PERF_EN.
- Defined: adds output `retired_count`, 16 bits. It increments once per EXEC completion (including HALT), saturates at 16'hFFFF, and resets to 0.
- Undefined: the port and its counter do not exist; all other behaviour is identical.

Test Plan:
- Release reset with PC at 8'h00 and `instr_valid` one cycle after each `fetch_req`, all SEQ → `next_address` 01,02,03 on successive EXEC cycles; `fetch_req` pulses every 3 cycles.
- PC=8'hFF, SEQ → `next_address`=8'h00 at EXEC.
- PC=8'h10, BZ target 8'h40: with `zero_flag`=1 → 8'h40; with `zero_flag`=0 → 8'h11. BNZ gives the inverse results.
- CALL 8'h80 from 8'h20, then RET at 8'h85 → 8'h80 then 8'h21. Five nested CALLs with STACK_DEPTH=4 → fifth yields A+1 and `stack_err`=1. RET on empty stack → A+1, `stack_err` stays set.
- EXEC with `mem_busy` high for 4 cycles → `next_address`=`current_address` for 4 cycles, then the target. HALT → `halted`=1, no further `fetch_req`. Assert reset → `next_address`=8'h00, `halted`=0.
- Reset asserted during WAIT → all outputs reach reset values immediately (asynchronously). After release, `fetch_req` pulses on the first cycle.
